// File: rtl/muldiv_pkg.sv
// Shared encodings for the multicycle multiply/divide engine.
package muldiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Iteration counter width; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle signed multiply/divide with start/busy/done handshake.
// Optional MULDIV_EARLY_OUT_EN skips iteration for trivially-resolved operands.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  logic               op_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0]   mag_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               busy_r, done_r, div_zero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_s, step_s, load_s;
  logic [WIDTH:0]     sum_s, trial_s;
  logic               qbit_s, dz_s, early_s;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.neg(a[WIDTH-1]), .value(a), .result(mag_a_s));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.neg(b[WIDTH-1]), .value(b), .result(mag_b_s));
  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_prod (.neg(neg_q_r), .value(acc_r), .result(prod_s));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_quo (.neg(neg_q_r), .value(acc_r[WIDTH-1:0]), .result(quo_s));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_rem (.neg(neg_r_r), .value(acc_r[2*WIDTH-1:WIDTH]), .result(rem_s));

  assign dz_s = (op == OP_DIV) && (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_s = (op == OP_MULT) ? ((a == '0) || (b == '0)) : (mag_a_s < mag_b_s);
`else
  assign early_s = 1'b0;
`endif

  // Accumulator seed: mult holds {partial, multiplier}; div holds {remainder, dividend}.
  always_comb begin
    load_s = {(2*WIDTH){1'b0}};
    if (op == OP_MULT) begin
      if (early_s) load_s = {(2*WIDTH){1'b0}};
      else         load_s = {{WIDTH{1'b0}}, mag_b_s};
    end else begin
      if (early_s) load_s = {mag_a_s, {WIDTH{1'b0}}};
      else         load_s = {{WIDTH{1'b0}}, mag_a_s};
    end
  end

  // BITS_PER_CYCLE shift-add or restoring-divide steps per clock.
  always_comb begin
    step_s  = acc_r;
    sum_s   = {(WIDTH+1){1'b0}};
    trial_s = {(WIDTH+1){1'b0}};
    qbit_s  = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_r == OP_MULT) begin
        sum_s  = {1'b0, step_s[2*WIDTH-1:WIDTH]} + (step_s[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
        step_s = {sum_s, step_s[WIDTH-1:1]};
      end else begin
        trial_s = {step_s[2*WIDTH-1:WIDTH], step_s[WIDTH-1]};
        if (trial_s >= {1'b0, mag_r}) begin
          trial_s = trial_s - {1'b0, mag_r};
          qbit_s  = 1'b1;
        end else begin
          qbit_s  = 1'b0;
        end
        step_s = {trial_s[WIDTH-1:0], step_s[WIDTH-2:0], qbit_s};
      end
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      op_r       <= OP_MULT;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      mag_r      <= '0;
      acc_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r       <= op;
            neg_q_r    <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_r    <= a[WIDTH-1];
            mag_r      <= (op == OP_MULT) ? mag_a_s : mag_b_s;
            acc_r      <= load_s;
            cnt_r      <= '0;
            busy_r     <= 1'b1;
            div_zero_r <= dz_s;
            if (dz_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (early_s) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_r <= step_s;
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_FIX;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_FIX: begin
          if (op_r == OP_MULT) begin
            {hi_r, lo_r} <= prod_s;
          end else begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop on done.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, op1 = 1'b0;
  logic [31:0] a1 = 32'd0, b1 = 32'd0;
  logic        busy1, done1, dz1;
  logic [31:0] hi1, lo1;

  logic        start4 = 1'b0, op4 = 1'b0;
  logic [31:0] a4 = 32'd0, b4 = 32'd0;
  logic        busy4, done4, dz4;
  logic [31:0] hi4, lo4;

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .clock(clk), .reset(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1)
  );

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (
    .clock(clk), .reset(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .div_zero(dz4), .hi(hi4), .lo(lo4)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic prev1 = 1'b0, prev4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic check_done(input int u, input logic prev, input logic [31:0] h,
                            input logic [31:0] l, input logic dz);
    exp_t e;
    chk($sformatf("u%0d_done_back_to_back", u), 64'(prev), 64'd0);
    if ((u == 1 && q1.size() == 0) || (u == 4 && q4.size() == 0)) begin
      chk($sformatf("u%0d_unexpected_done", u), 64'd1, 64'd0);
    end else begin
      if (u == 1) e = q1.pop_front();
      else        e = q4.pop_front();
      chk($sformatf("u%0d_hi", u), 64'(h), 64'(e.hi));
      chk($sformatf("u%0d_lo", u), 64'(l), 64'(e.lo));
      chk($sformatf("u%0d_div_zero", u), 64'(dz), 64'(e.dz));
      chk($sformatf("u%0d_done_cycle", u), 64'(cyc), 64'(e.due));
    end
  endtask

  always @(negedge clk) begin
    if (done1) check_done(1, prev1, hi1, lo1, dz1);
    if (done4) check_done(4, prev4, hi4, lo4, dz4);
    prev1 <= done1;
    prev4 <= done4;
  end

  // The start edge is the next posedge (cyc+1); done is seen at the negedge lat-1 edges later.
  task automatic issue(input bit unit4, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
    exp_t e;
    @(negedge clk);
    if (unit4) begin
      start4 = 1'b1; op4 = op; a4 = a; b4 = b;
    end else begin
      start1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
    e.hi = hi; e.lo = lo; e.dz = dz; e.due = cyc + lat;
    if (unit4) q4.push_back(e);
    else       q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q4.size() != 0) begin
      chk("done_timeout", 64'(q1.size() + q4.size()), 64'd0);
      q1.delete();
      q4.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input bit unit4, input logic op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
    issue(unit4, op, a, b, hi, lo, dz, lat);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy1), 64'd0);
    chk("reset_done", 64'(done1), 64'd0);
    chk("reset_div_zero", 64'(dz1), 64'd0);
    chk("reset_hilo", {hi1, lo1}, 64'd0);
    chk("reset_hilo_u4", {hi4, lo4}, 64'd0);

    run(1'b0, 1'b0, 32'd6,          32'd7,          32'h00000000, 32'h0000002A, 1'b0, 34);
    run(1'b0, 1'b0, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
    run(1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run(1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 1'b0, 34);
    run(1'b0, 1'b0, 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 1'b0, 34);
    run(1'b0, 1'b1, 32'd68,         32'd7,          32'h00000005, 32'h00000009, 1'b0, 34);
    run(1'b0, 1'b1, 32'd123,        32'd0,          32'h00000005, 32'h00000009, 1'b1, 1);
    run(1'b0, 1'b1, 32'd100,        32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFF2, 1'b0, 34);

    run(1'b1, 1'b0, 32'd12345,      32'hFFFFFD5A,   32'hFFFFFFFF, 32'hFF80490A, 1'b0, 10);
    run(1'b1, 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 10);

    // A divide-by-zero start during RUN must be dropped entirely.
    issue(1'b0, 1'b0, 32'd1000, 32'd1000, 32'h00000000, 32'h000F4240, 1'b0, 34);
    repeat (5) @(negedge clk);
    chk("busy_during_run", 64'(busy1), 64'd1);
    start1 = 1'b1; op1 = 1'b1; a1 = 32'd1; b1 = 32'd0;
    @(negedge clk);
    start1 = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Abort mid-operation: outputs clear at once and no done follows.
    @(negedge clk);
    start1 = 1'b1; op1 = 1'b0; a1 = 32'd6; b1 = 32'd7;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    chk("abort_hilo", {hi1, lo1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("abort_idle_busy", 64'(busy1), 64'd0);
    chk("abort_hilo_held", {hi1, lo1}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
